moxie_wb_sram_ctrl: RTL and testbench
=====================================

// Module: moxie_wb_sram_ctrl
// PURPOSE
//  Wishbone classic slave that sits directly downstream of the moxie core's shared 16-bit bus (post I/D arbitration).
//  Turns each single-word Wishbone cycle into a timed access to an external 16-bit asynchronous SRAM.
//  Read, write and hold timing are fixed by parameters.
//  Tristate pads live at board top level; this block drives separate dq_o, dq_i and dq_oe_o.
// PARAMETERS
//  ADDR_WIDTH  18  SRAM word-address width; uses wb_adr_i[ADDR_WIDTH:1] and ignores the upper bits (aliasing)
//  RD_WAIT     2   cycles oe_n is held low before read data is captured (>=1)
//  WR_WAIT     2   cycles we_n is held low (>=1)
//  HOLD_CYC    1   cycles after we_n rises that address and data stay driven (>=0)
// PORTS
//  clk_i        in   1   core clock
//  rst_i        in   1   asynchronous reset, active high
//  wb_cyc_i     in   1   bus cycle
//  wb_stb_i     in   1   strobe
//  wb_we_i      in   1   1=write
//  wb_adr_i     in   32  byte address
//  wb_sel_i     in   2   byte lanes; [1]=dat[15:8], [0]=dat[7:0]
//  wb_dat_i     in   16  write data
//  wb_dat_o     out  16  read data
//  wb_ack_o     out  1   single-cycle acknowledge
//  sram_addr_o  out  ADDR_WIDTH  word address
//  sram_dq_o    out  16  data to pads
//  sram_dq_i    in   16  data from pads
//  sram_dq_oe_o out  1   pad output enable
//  sram_ce_n_o  out  1   chip enable, active low
//  sram_oe_n_o  out  1   output enable, active low
//  sram_we_n_o  out  1   write enable, active low
//  sram_ub_n_o  out  1   upper-byte enable, active low
//  sram_lb_n_o  out  1   lower-byte enable, active low
// BEHAVIOUR
//  Reset (async, immediate, also mid-access):
//   - state=IDLE, wb_ack_o=0, wb_dat_o=0
//   - ce_n/oe_n/we_n/ub_n/lb_n=1, dq_oe_o=0, addr=0, dq_o=0
//  FSM: IDLE -> SETUP -> ACCESS -> [HOLD, writes with HOLD_CYC>0] -> ACK -> IDLE
//  IDLE:
//   - accepts when wb_cyc_i & wb_stb_i
//   - registers addr, we, sel and write data
//  SETUP (1 cycle):
//   - ce_n=0
//   - read: ub_n=lb_n=0
//   - write: ub_n=~sel[1], lb_n=~sel[0], dq_oe_o=1
//  ACCESS, read (RD_WAIT cycles):
//   - oe_n=0
//   - sram_dq_i captured into wb_dat_o on the last ACCESS edge
//  ACCESS, write (WR_WAIT cycles):
//   - we_n=0, data driven
//  HOLD (HOLD_CYC cycles):
//   - we_n=1, ce_n=0, addr/data/dq_oe held
//  ACK (1 cycle):
//   - ce_n=1, dq_oe_o=0
//   - wb_ack_o=1 only if wb_cyc_i & wb_stb_i are still high; otherwise the access completes silently
//  Latency, request edge to ack-high cycle:
//   - read: 2+RD_WAIT
//   - write: 2+WR_WAIT+HOLD_CYC
//  Handshake rules:
//   - wb_dat_o is stable from the ACK cycle until the next read capture
//   - ack never asserted in two consecutive cycles; IDLE always sits between accesses
//  Aborts and overlaps:
//   - cyc dropped mid-access: SRAM cycle still completes (no truncated we_n pulse)
//   - new requests wait in IDLE
//  Counter:
//   - width $clog2(max(RD_WAIT,WR_WAIT,HOLD_CYC)+1)
//   - loaded on state entry, decremented per cycle, exits at 0; never wraps
//  All SRAM control outputs are registered (glitch-free at the pads).
//  sel=2'b00 on a write:
//   - we_n still pulses, ub_n=lb_n=1, no bytes change
//   - ack issued normally
// STRUCTURE
//  - Single module.
//  - State encodings and the default timing constants are `defines in shared header sram_defines.h, included alongside defines.h.
//  - No sub-module is natural; the wait counter stays inline.
// TESTING
//  1 Write adr=0x0000_0010, sel=11, dat=0xBEEF:
//    - sram_addr=0x08, we_n low exactly 2 cycles
//    - ack at cycle 5; memory model word 0x08=0xBEEF
//  2 Read adr=0x10 after test 1:
//    - oe_n low 2 cycles, ack at cycle 4
//    - wb_dat_o=0xBEEF
//  3 Write sel=10, dat=0x12xx over word 0xBEEF:
//    - ub_n=0, lb_n=1
//    - readback 0x12EF
//  4 Read; drop cyc during ACCESS:
//    - no ack, ce_n returns high on schedule
//    - next read of 0x20 acks normally
//  5 Assert rst_i mid-write (we_n low):
//    - same cycle, all *_n=1, dq_oe_o=0, ack=0
//    - after release, IDLE accepts a new request
//  6 Back-to-back reads with stb held continuously:
//    - one ack per access
//    - at least one IDLE cycle (ce_n=1) between accesses

Source files
------------

// File: rtl/moxie_wb_sram_ctrl_pkg.sv
// Shared types and default timing for the moxie Wishbone-to-async-SRAM bridge.
package moxie_wb_sram_ctrl_pkg;

  // Access sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ACK    = 3'd4
  } state_e;

  // Default SRAM geometry and timing (cycles of clk_i)
  localparam int DEF_ADDR_WIDTH = 18;
  localparam int DEF_RD_WAIT    = 2;
  localparam int DEF_WR_WAIT    = 2;
  localparam int DEF_HOLD_CYC   = 1;

  // Largest of three timing constants; sizes the shared wait counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/moxie_wb_sram_ctrl.sv
// Wishbone classic slave driving a 16-bit asynchronous SRAM with fixed
// setup / access / hold timing. All pad-facing controls are registered.
module moxie_wb_sram_ctrl
  import moxie_wb_sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_WAIT    = DEF_RD_WAIT,
  parameter int WR_WAIT    = DEF_WR_WAIT,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [1:0]            wb_sel_i,
  input  logic [15:0]           wb_dat_i,
  output logic [15:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [15:0]           sram_dq_o,
  input  logic [15:0]           sram_dq_i,
  output logic                  sram_dq_oe_o,
  output logic                  sram_ce_n_o,
  output logic                  sram_oe_n_o,
  output logic                  sram_we_n_o,
  output logic                  sram_ub_n_o,
  output logic                  sram_lb_n_o
);

  localparam int CNT_MAX = max3(RD_WAIT, WR_WAIT, HOLD_CYC);
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  // Counter load values: the counter runs N-1 .. 0, so a phase lasts N cycles
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q;
  logic [1:0]              sel_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]             wdat_q, rdat_q;
  logic                    ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q, dq_oe_q;
  logic                    ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d, dq_oe_d;

  logic       accept;
  logic       we_d;
  logic [1:0] sel_d;
  logic       busy_d;
  logic       rd_capture;

  // Byte-address LSB and bits above the SRAM window are deliberately ignored
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb_adr_i[31:ADDR_WIDTH+1], wb_adr_i[0]};

  assign accept     = (state_q == ST_IDLE) && wb_cyc_i && wb_stb_i;
  // Request attributes as they will be after this edge
  assign we_d       = accept ? wb_we_i  : we_q;
  assign sel_d      = accept ? wb_sel_i : sel_q;
  assign rd_capture = (state_q == ST_ACCESS) && !we_q && (cnt_q == '0);

  // Next state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = we_q ? WR_LOAD : RD_LOAD;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          if (we_q && (HOLD_CYC > 0)) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            state_d = ST_ACK;
          end
        end
      end
      ST_HOLD:   if (cnt_q == '0) state_d = ST_ACK;
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Pad controls decoded from the upcoming state so they leave a flop clean
  always_comb begin
    busy_d  = (state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_HOLD);
    ce_n_d  = !busy_d;
    oe_n_d  = !((state_d == ST_ACCESS) && !we_d);
    we_n_d  = !((state_d == ST_ACCESS) && we_d);
    ub_n_d  = busy_d ? (we_d ? !sel_d[1] : 1'b0) : 1'b1;
    lb_n_d  = busy_d ? (we_d ? !sel_d[0] : 1'b0) : 1'b1;
    dq_oe_d = busy_d && we_d;
  end

  // State, counter and pad-control registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  // Request latch on accept; read data captured on the final ACCESS edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q   <= 1'b0;
      sel_q  <= 2'b00;
      addr_q <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
    end else begin
      if (accept) begin
        we_q   <= wb_we_i;
        sel_q  <= wb_sel_i;
        addr_q <= wb_adr_i[ADDR_WIDTH:1];
        wdat_q <= wb_dat_i;
      end
      if (rd_capture) rdat_q <= sram_dq_i;
    end
  end

  // Ack only while the master still holds the cycle; otherwise finish silently
  assign wb_ack_o     = (state_q == ST_ACK) && wb_cyc_i && wb_stb_i;
  assign wb_dat_o     = rdat_q;
  assign sram_addr_o  = addr_q;
  assign sram_dq_o    = wdat_q;
  assign sram_dq_oe_o = dq_oe_q;
  assign sram_ce_n_o  = ce_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;
  assign sram_ub_n_o  = ub_n_q;
  assign sram_lb_n_o  = lb_n_q;

endmodule

// File: tb/tb_moxie_wb_sram_ctrl.sv
// Bench for moxie_wb_sram_ctrl: behavioural SRAM, directed requests, and a
// scoreboard monitor that checks every ack against queued expectations.
module tb_moxie_wb_sram_ctrl;

  localparam int AW = 18;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0]   wb_adr_i = '0;
  logic [1:0]    wb_sel_i = '0;
  logic [15:0]   wb_dat_i = '0;
  logic [15:0]   wb_dat_o;
  logic          wb_ack_o;
  logic [AW-1:0] sram_addr_o;
  logic [15:0]   sram_dq_o, sram_dq_i;
  logic          sram_dq_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic          sram_ub_n_o, sram_lb_n_o;

  moxie_wb_sram_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .sram_addr_o(sram_addr_o), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe_o(sram_dq_oe_o), .sram_ce_n_o(sram_ce_n_o),
    .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o),
    .sram_ub_n_o(sram_ub_n_o), .sram_lb_n_o(sram_lb_n_o)
  );

  always #5 clk_i = ~clk_i;

  // Edge counter: after the k-th rising edge cyc_cnt == k
  int cyc_cnt = 0;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  // Behavioural SRAM (256 words, byte lanes honoured)
  logic [15:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  always @(posedge clk_i)
    if (!sram_ce_n_o && !sram_we_n_o) begin
      if (!sram_ub_n_o) mem[sram_addr_o[7:0]][15:8] <= sram_dq_o[15:8];
      if (!sram_lb_n_o) mem[sram_addr_o[7:0]][7:0]  <= sram_dq_o[7:0];
    end
  assign sram_dq_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[7:0]] : 16'h0000;

  typedef struct {
    logic        rd;
    logic [15:0] dat;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per ack; also enforces the idle gap after ack
  initial begin
    bit   prev_ack;
    exp_t e;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) prev_ack = 1'b0;
      else begin
        if (prev_ack) begin
          chk("ack_gap", {31'd0, wb_ack_o}, 32'd0);
          chk("idle_ce_n", {31'd0, sram_ce_n_o}, 32'd1);
        end
        if (wb_ack_o) begin
          if (sb.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_ack: ack at cycle %0d with nothing outstanding", cyc_cnt);
          end else begin
            e = sb.pop_front();
            chk("ack_cycle", cyc_cnt, e.cyc);
            if (e.rd) chk("rd_data", {16'd0, wb_dat_o}, {16'd0, e.dat});
          end
        end
        prev_ack = wb_ack_o;
      end
    end
  end

  // Observations collected while waiting for an ack
  int          n_we, n_oe;
  logic        ub_w, lb_w;
  logic [AW-1:0] addr_w;

  // Drive a request; cycle 1 is the SETUP cycle right after the request edge
  task automatic start_req(input logic we, input logic [31:0] adr, input logic [1:0] sel,
                           input logic [15:0] dat, input logic [15:0] exp_rd,
                           input int lat, input bit push);
    exp_t e;
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
    e.rd = !we; e.dat = exp_rd; e.cyc = cyc_cnt + lat;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_ack(input bit keep, output int acyc);
    acyc = -1; n_we = 0; n_oe = 0; ub_w = 1'b1; lb_w = 1'b1; addr_w = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (!sram_we_n_o) begin n_we++; ub_w = sram_ub_n_o; lb_w = sram_lb_n_o; addr_w = sram_addr_o; end
      if (!sram_oe_n_o) n_oe++;
      if (wb_ack_o) begin acyc = cyc_cnt; break; end
    end
    if (acyc < 0) begin
      n_chk++; n_err++;
      $display("FAIL ack_timeout: no ack within 30 cycles");
    end
    #1;
    if (!keep) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; end
  endtask

  initial begin
    int   acyc, r;
    exp_t e;
    bit   seen;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_ctrl_n", {27'd0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o}, 32'h1F);
    chk("rst_dq_oe", {31'd0, sram_dq_oe_o}, 32'd0);
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_dat", {16'd0, wb_dat_o}, 32'd0);
    chk("rst_addr", {14'd0, sram_addr_o}, 32'd0);
    #1 rst_i = 1'b0;

    // 1: full-word write, ack at cycle 5
    start_req(1'b1, 32'h0000_0010, 2'b11, 16'hBEEF, 16'h0, 5, 1'b1);
    wait_ack(1'b0, acyc);
    chk("t1_we_len", n_we, 2);
    chk("t1_addr", {14'd0, addr_w}, 32'h08);
    chk("t1_mem", {16'd0, mem[8]}, 32'hBEEF);

    // 2: read back, ack at cycle 4
    start_req(1'b0, 32'h0000_0010, 2'b11, 16'h0, 16'hBEEF, 4, 1'b1);
    wait_ack(1'b0, acyc);
    chk("t2_oe_len", n_oe, 2);

    // 3: upper byte only
    start_req(1'b1, 32'h0000_0010, 2'b10, 16'h12AB, 16'h0, 5, 1'b1);
    wait_ack(1'b0, acyc);
    chk("t3_ub_lb", {30'd0, ub_w, lb_w}, 32'b01);
    start_req(1'b0, 32'h0000_0010, 2'b11, 16'h0, 16'h12EF, 4, 1'b1);
    wait_ack(1'b0, acyc);

    // sel=00 write: pulse happens, no byte changes
    start_req(1'b1, 32'h0000_0010, 2'b00, 16'hFFFF, 16'h0, 5, 1'b1);
    wait_ack(1'b0, acyc);
    chk("s0_we_len", n_we, 2);
    chk("s0_ub_lb", {30'd0, ub_w, lb_w}, 32'b11);
    chk("s0_mem", {16'd0, mem[8]}, 32'h12EF);

    // 4: seed word 0x10, then abort a read mid-ACCESS
    start_req(1'b1, 32'h0000_0020, 2'b11, 16'hA5C3, 16'h0, 5, 1'b1);
    wait_ack(1'b0, acyc);
    start_req(1'b0, 32'h0000_0010, 2'b11, 16'h0, 16'h0, 4, 1'b0);
    r = cyc_cnt + 1;   // cycle count at the SETUP cycle
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (!sram_oe_n_o) begin seen = 1'b1; break; end
    end
    chk("t4_oe_seen", {31'd0, seen}, 32'd1);
    #1 wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (cyc_cnt == r + 2) chk("t4_ce_last_access", {31'd0, sram_ce_n_o}, 32'd0);
      if (cyc_cnt == r + 3) begin chk("t4_ce_ack_slot", {31'd0, sram_ce_n_o}, 32'd1); break; end
    end
    start_req(1'b0, 32'h0000_0020, 2'b11, 16'h0, 16'hA5C3, 4, 1'b1);
    wait_ack(1'b0, acyc);

    // 5: async reset while we_n is low
    start_req(1'b1, 32'h0000_0040, 2'b11, 16'h5555, 16'h0, 5, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (!sram_we_n_o) begin seen = 1'b1; break; end
    end
    chk("t5_we_seen", {31'd0, seen}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("t5_ctrl_n", {27'd0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o}, 32'h1F);
    chk("t5_dq_oe", {31'd0, sram_dq_oe_o}, 32'd0);
    chk("t5_ack", {31'd0, wb_ack_o}, 32'd0);
    sb.delete();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk_i); #1 rst_i = 1'b0;
    start_req(1'b0, 32'h0000_0010, 2'b11, 16'h0, 16'h12EF, 4, 1'b1);
    wait_ack(1'b0, acyc);

    // 6: back-to-back reads, stb held through the ack
    start_req(1'b0, 32'h0000_0010, 2'b11, 16'h0, 16'h12EF, 4, 1'b1);
    wait_ack(1'b1, acyc);
    wb_adr_i = 32'h0000_0020;
    // ACK cycle, one IDLE cycle, then SETUP is cycle 1 of the next access
    e.rd = 1'b1; e.dat = 16'hA5C3; e.cyc = acyc + 2 + 3;
    sb.push_back(e);
    wait_ack(1'b0, acyc);

    repeat (3) @(negedge clk_i);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
